qbus_master_cycle: RTL
======================

Name: qbus_master_cycle

Overview:
- FPGA-side QBUS bus-master cycle engine. Performs single DATI (read) and DATO (write) cycles on request from an internal client (DMA engine).
- Drives TSYNC/TDIN/TDOUT and the DAL transceiver controls (DALbe_L, DALtx, DALst, ZDAL, ZBS7, ZWTBT) through qdrv, and watches RRPLY.
- It is the initiator end of the cycles that pmo and the slave register blocks answer.
- Bus arbitration (DMR/DMG/SACK) is handled outside this block. It only runs cycles while `mastered` is high.

Parameters:
- CLK_NS, 50, qclk period in ns (20 MHz); informational only.
- ADDR_SETUP, 3, cycles ZDAL address is valid before TSYNC asserts (150 ns).
- ADDR_HOLD, 2, cycles address is held after TSYNC before DIN/data phase (100 ns).
- DATA_SETUP, 2, cycles write data is valid before TDOUT asserts (100 ns).
- RPLY_DESKEW, 3, cycles from synchronized RRPLY to sampling read data (150 ns).
- DATA_HOLD, 2, cycles write data is held after TDOUT negates (100 ns).
- NXM_CYCLES, 200, cycles to wait for RRPLY assert or negate before declaring NXM (10 us).

Ports:
- qclk  in  1  system clock, 20 MHz.
- reset  in  1  asynchronous, active-high reset.
- mastered  in  1  arbiter has granted bus mastership (SACK held).
- req  in  1  start cycle; sampled only in IDLE.
- write  in  1  1 = DATO, 0 = DATI.
- addr  in  22  bus address.
- bs7  in  1  I/O page select, driven on ZBS7 during the address phase.
- wdata  in  16  write data.
- rdata  out  16  read data, valid when done=1 and write=0.
- done  out  1  one-cycle pulse at cycle end.
- nxm  out  1  valid with done; 1 = RRPLY timeout.
- busy  out  1  high from req accepted until done.
- DALbe_L  out  1  DAL driver enable, active low.
- DALtx  out  1  DAL direction; 1 = FPGA drives bus.
- DALst  out  1  strobe ZDAL into the transceiver output latches.
- ZDAL  inout  22  FPGA-side DAL.
- ZBS7  inout  1  FPGA-side BS7.
- ZWTBT  inout  1  FPGA-side WTBT.
- TSYNC  out  1  assert BSYNC, active high.
- TDIN  out  1  assert BDIN, active high.
- TDOUT  out  1  assert BDOUT, active high.
- RRPLY  in  1  received BRPLY, asynchronous; 2-flop synchronized internally.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; counters are cleared.
  - TSYNC=TDIN=TDOUT=DALtx=DALst=done=nxm=busy=0; DALbe_L=1; rdata=0.
  - ZDAL/ZBS7/ZWTBT are released to high-Z.
  - Reset mid-cycle drops all bus strobes immediately; no done pulse follows.
- ZDAL/ZBS7/ZWTBT are driven only while DALtx=1 and are otherwise high-Z. DALbe_L = ~DALtx.
- DALst pulses for 1 cycle, one cycle after new values are placed on ZDAL.
- IDLE: if req && mastered, latch addr/bs7/write/wdata, set busy, go to ADDR. A req with mastered=0 is ignored; busy stays 0.
- ADDR (ADDR_SETUP cycles):
  - DALtx=1; ZDAL=addr; ZBS7=bs7; ZWTBT=write.
  - Then set TSYNC=1 and go to AHOLD.
- AHOLD (ADDR_HOLD cycles): address is held.
  - If write: ZDAL={6'b0,wdata}, ZBS7=0, ZWTBT=0, restrobe DALst, go to DSETUP.
  - If read: DALtx=0, TDIN=1, go to WAIT_RPLY.
- DSETUP (DATA_SETUP cycles): then TDOUT=1, go to WAIT_RPLY.
- WAIT_RPLY: wait for synchronized RRPLY=1.
  - Read: go to DESKEW.
  - Write: TDOUT=0, go to DHOLD.
  - A timeout counter starts at TDIN/TDOUT assertion. On reaching NXM_CYCLES: negate TDIN/TDOUT, set nxm, go to END.
- DESKEW (RPLY_DESKEW cycles): then rdata=ZDAL[15:0], TDIN=0, go to WAIT_NRPLY.
- DHOLD (DATA_HOLD cycles): then DALtx=0, go to WAIT_NRPLY.
- WAIT_NRPLY: wait for synchronized RRPLY=0, then go to END.
  - Timeout of NXM_CYCLES sets nxm and goes to END.
  - rdata is kept as sampled.
- END: TSYNC=0; DALtx=0; done=1 for 1 cycle with nxm valid; busy=0; go to IDLE.
  - nxm clears on the next req accept.
  - A new cycle may start no earlier than the cycle after done.
- If mastered drops mid-cycle, the cycle still completes. mastered is checked only in IDLE.
- RRPLY already asserted at TSYNC assertion is ignored; WAIT_RPLY still requires RRPLY=1.
- Timeout counter width is ceil(log2(NXM_CYCLES+1)). It saturates and never wraps.

Test Plan:
- Read 0o777570 with bs7=1; slave replies with DAL=0o177777 (inverted on the bus) 300 ns after DIN → done with nxm=0, rdata=16'o177777.
  - Check TSYNC rises 150 ns after ZDAL=0o777570.
  - Check TDIN rises 100 ns after TSYNC.
  - Check TSYNC falls only after RRPLY negates.
- Write 0o054321 to 0o17774440 with bs7=1 →
  - ZWTBT=1 during the address phase.
  - ZDAL=0o054321 at least 100 ns before TDOUT.
  - TDOUT falls within 2 synchronizer + 1 cycles of RRPLY; data held 100 ns after.
  - done, nxm=0.
- Read 0o400 with no responder → TDIN negates after 200 cycles (10 us), done=1, nxm=1, TSYNC=0 the same cycle.
- Responder holds RRPLY asserted forever after a write → nxm=1 after 200 cycles in WAIT_NRPLY; bus strobes released.
- Assert reset while in WAIT_RPLY of a read → TSYNC/TDIN/DALtx=0 and DALbe_L=1 asynchronously; no done pulse; the next req runs normally.
- req with mastered=0 → no bus activity, busy stays 0. Then raise mastered → a held req starts the cycle the next clock.

Source files
------------

// File: rtl/qbus_master_cycle_if.sv
// rtl/qbus_master_cycle_if.sv - client handshake and QBUS strobe bundle for the master cycle engine
//
// Purpose:
//   Groups the client request/response signals and the non-tristate QBUS
//   transceiver controls used by qbus_master_cycle. The tristate DAL/BS7/WTBT
//   pins stay plain inout ports on the engine so they resolve as real nets.
//
// Signals:
//   mastered        arbiter has granted bus mastership
//   req/write       cycle request, 1 = DATO, 0 = DATI
//   addr[21:0]      bus address
//   bs7             I/O page select for the address phase
//   wdata[15:0]     write data
//   rdata[15:0]     read data, valid with done on a DATI
//   done/nxm        end-of-cycle pulse and timeout flag
//   busy            cycle in progress
//   DALbe_L/DALtx   DAL driver enable (active low) and direction
//   DALst           transceiver output latch strobe
//   TSYNC/TDIN/TDOUT bus strobes
//   RRPLY           received BRPLY, asynchronous
//
// Modports:
//   master  the cycle engine
//   slave   the client plus the far side of the transceivers

interface qbus_master_cycle_if;
  logic        mastered;
  logic        req;
  logic        write;
  logic [21:0] addr;
  logic        bs7;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done;
  logic        nxm;
  logic        busy;
  logic        DALbe_L;
  logic        DALtx;
  logic        DALst;
  logic        TSYNC;
  logic        TDIN;
  logic        TDOUT;
  logic        RRPLY;

  modport master (
    input  mastered, req, write, addr, bs7, wdata, RRPLY,
    output rdata, done, nxm, busy, DALbe_L, DALtx, DALst, TSYNC, TDIN, TDOUT
  );

  modport slave (
    output mastered, req, write, addr, bs7, wdata, RRPLY,
    input  rdata, done, nxm, busy, DALbe_L, DALtx, DALst, TSYNC, TDIN, TDOUT
  );
endinterface

// File: rtl/qbus_master_cycle.sv
// rtl/qbus_master_cycle.sv - QBUS bus-master DATI/DATO cycle engine
//
// Purpose:
//   Runs single DATI (read) and DATO (write) cycles on the QBUS for an
//   internal client while bus mastership is held. Sequences the DAL
//   transceivers, TSYNC/TDIN/TDOUT and waits on a synchronized RRPLY with a
//   saturating no-response (NXM) timeout.
//
// Ports:
//   qclk         system clock (20 MHz)
//   reset        asynchronous, active-high reset
//   q            qbus_master_cycle_if.master: client handshake and bus strobes
//   ZDAL[21:0]   FPGA-side DAL, driven only while DALtx=1
//   ZBS7         FPGA-side BS7, driven only while DALtx=1
//   ZWTBT        FPGA-side WTBT, driven only while DALtx=1
//
// All bus strobes are decoded from the state register, so an asynchronous
// reset drops them immediately without waiting for a clock edge.

module qbus_master_cycle #(
  parameter int CLK_NS      = 50,   // qclk period, ns (informational)
  parameter int ADDR_SETUP  = 3,    // address valid before TSYNC
  parameter int ADDR_HOLD   = 2,    // address held after TSYNC
  parameter int DATA_SETUP  = 2,    // write data valid before TDOUT
  parameter int RPLY_DESKEW = 3,    // synchronized RRPLY to read-data sample
  parameter int DATA_HOLD   = 2,    // write data held after TDOUT negates
  parameter int NXM_CYCLES  = 200   // RRPLY assert/negate timeout
) (
  input  logic                qclk,
  input  logic                reset,
  qbus_master_cycle_if.master q,
  inout  wire  [21:0]         ZDAL,
  inout  wire                 ZBS7,
  inout  wire                 ZWTBT
);

  // The strobe decode relies on a mid-phase DALst pulse, so the setup
  // phases need at least two cycles.
  if (CLK_NS <= 0 || ADDR_SETUP < 2 || ADDR_HOLD < 1 || DATA_SETUP < 2 ||
      RPLY_DESKEW < 1 || DATA_HOLD < 1 || NXM_CYCLES < 2) begin : g_param_check
    $error("qbus_master_cycle: unsupported timing parameters");
  end

  localparam int CNT_W = $clog2(NXM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NXM_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_AHOLD,
    S_DSETUP,
    S_WAIT_RPLY,
    S_DESKEW,
    S_DHOLD,
    S_WAIT_NRPLY,
    S_END
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;          // cycles spent in the current state

  // Request latched at accept time
  logic [21:0]      addr_q;
  logic             bs7_q;
  logic             write_q;
  logic [15:0]      wdata_q;

  logic [15:0]      rdata_q;
  logic             nxm_q;

  logic             rply_meta;
  logic             rply_s;

  logic             accept;
  logic             timeout;
  logic             nxm_set;
  logic             rdata_take;

  // Decoded bus outputs
  logic             tsync;
  logic             tdin;
  logic             tdout;
  logic             dal_tx;
  logic             dal_st;
  logic             done;
  logic             busy;
  logic [21:0]      dal_out;
  logic             bs7_out;
  logic             wtbt_out;

  // The master never samples the upper DAL bits or BS7/WTBT back.
  logic             unused_bus_in;
  assign unused_bus_in = ^{ZDAL[21:16], ZBS7, ZWTBT};

  // ---------------------------------------------------------------------
  // RRPLY arrives asynchronously from the bus receivers.
  // ---------------------------------------------------------------------
  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      rply_meta <= 1'b0;
      rply_s    <= 1'b0;
    end else begin
      rply_meta <= q.RRPLY;
      rply_s    <= rply_meta;
    end
  end

  assign accept     = (state == S_IDLE) && q.req && q.mastered;
  assign timeout    = (cnt == CNT_W'(NXM_CYCLES - 1));
  assign nxm_set    = ((state == S_WAIT_RPLY)  && !rply_s && timeout) ||
                      ((state == S_WAIT_NRPLY) &&  rply_s && timeout);
  assign rdata_take = (state == S_DESKEW) && (cnt == CNT_W'(RPLY_DESKEW - 1));

  // ---------------------------------------------------------------------
  // FSM: state register and per-state cycle counter. The counter restarts
  // on every state change and saturates rather than wrapping.
  // ---------------------------------------------------------------------
  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic. mastered only gates the start of a cycle; once
  // running, a cycle always runs to END.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (cnt == CNT_W'(ADDR_SETUP - 1)) state_nxt = S_AHOLD;
      end
      S_AHOLD: begin
        if (cnt == CNT_W'(ADDR_HOLD - 1)) state_nxt = write_q ? S_DSETUP : S_WAIT_RPLY;
      end
      S_DSETUP: begin
        if (cnt == CNT_W'(DATA_SETUP - 1)) state_nxt = S_WAIT_RPLY;
      end
      S_WAIT_RPLY: begin
        if (rply_s)       state_nxt = write_q ? S_DHOLD : S_DESKEW;
        else if (timeout) state_nxt = S_END;
      end
      S_DESKEW: begin
        if (cnt == CNT_W'(RPLY_DESKEW - 1)) state_nxt = S_WAIT_NRPLY;
      end
      S_DHOLD: begin
        if (cnt == CNT_W'(DATA_HOLD - 1)) state_nxt = S_WAIT_NRPLY;
      end
      S_WAIT_NRPLY: begin
        if (!rply_s || timeout) state_nxt = S_END;
      end
      S_END: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output decode. DALst fires on the second cycle of each phase that
  // puts new values on ZDAL, giving the transceiver inputs a cycle to settle.
  // ---------------------------------------------------------------------
  always_comb begin
    tsync    = 1'b0;
    tdin     = 1'b0;
    tdout    = 1'b0;
    dal_tx   = 1'b0;
    dal_st   = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    dal_out  = addr_q;
    bs7_out  = 1'b0;
    wtbt_out = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ADDR: begin
        dal_tx   = 1'b1;
        bs7_out  = bs7_q;
        wtbt_out = write_q;
        dal_st   = (cnt == CNT_W'(1));
      end
      S_AHOLD: begin
        tsync    = 1'b1;
        dal_tx   = 1'b1;
        bs7_out  = bs7_q;
        wtbt_out = write_q;
      end
      S_DSETUP: begin
        tsync   = 1'b1;
        dal_tx  = 1'b1;
        dal_out = {6'b0, wdata_q};
        dal_st  = (cnt == CNT_W'(1));
      end
      S_WAIT_RPLY: begin
        tsync = 1'b1;
        if (write_q) begin
          dal_tx  = 1'b1;
          dal_out = {6'b0, wdata_q};
          tdout   = 1'b1;
        end else begin
          tdin = 1'b1;
        end
      end
      S_DESKEW: begin
        tsync = 1'b1;
        tdin  = 1'b1;
      end
      S_DHOLD: begin
        tsync   = 1'b1;
        dal_tx  = 1'b1;
        dal_out = {6'b0, wdata_q};
      end
      S_WAIT_NRPLY: begin
        tsync = 1'b1;
      end
      S_END: begin
        done = 1'b1;
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request latch, read data capture and NXM flag. nxm stays visible after
  // done until the next cycle is accepted.
  // ---------------------------------------------------------------------
  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      bs7_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= q.addr;
        bs7_q   <= q.bs7;
        write_q <= q.write;
        wdata_q <= q.wdata;
        nxm_q   <= 1'b0;
      end
      if (nxm_set) begin
        nxm_q <= 1'b1;
      end
      if (rdata_take) begin
        rdata_q <= ZDAL[15:0];
      end
    end
  end

  assign ZDAL  = dal_tx ? dal_out  : {22{1'bz}};
  assign ZBS7  = dal_tx ? bs7_out  : 1'bz;
  assign ZWTBT = dal_tx ? wtbt_out : 1'bz;

  assign q.TSYNC   = tsync;
  assign q.TDIN    = tdin;
  assign q.TDOUT   = tdout;
  assign q.DALtx   = dal_tx;
  assign q.DALbe_L = ~dal_tx;
  assign q.DALst   = dal_st;
  assign q.done    = done;
  assign q.busy    = busy;
  assign q.nxm     = nxm_q;
  assign q.rdata   = rdata_q;

endmodule
